wb_intercon_n: RTL and testbench

Parametrised, registered Wishbone classic-cycle interconnect joining one bus master (the J1 core) to `NUM_SLAVES` slaves via a programmable base/mask address map. It generalises the fixed four-slave interconnect in the USB device top. It adds three things:

- a bus-error response for unmapped addresses;
- a per-access watchdog that terminates hung slave cycles;
- saturating error telemetry.

It sits between `j1_wb` and the ROM, RAM, board I/O and USB controller slaves.

---
 rtl/wb_intercon_pkg.sv | 14 +
 rtl/wb_addr_decoder.sv | 26 ++
 rtl/wb_intercon_n.sv | 160 ++++++++++++++++
 tb/tb_wb_intercon_n.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_intercon_pkg.sv
// Shared types for the parametrised Wishbone interconnect.
package wb_intercon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } intercon_state_t;

  typedef logic [3:0] slave_idx_t;

  localparam slave_idx_t UNMAPPED_IDX = 4'hF;

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module wb_addr_decoder
  import wb_intercon_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE [NUM_SLAVES] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000},
  parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK [NUM_SLAVES] = '{16'hC000, 16'hC000, 16'hC000, 16'hC000}
)(
  input  logic [ADDR_WIDTH-1:0] m_adr,
  output logic                  hit,
  output slave_idx_t            idx
);

  always_comb begin
    hit = 1'b0;
    idx = UNMAPPED_IDX;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((m_adr & SLAVE_MASK[i]) == SLAVE_BASE[i])) begin
        hit = 1'b1;
        idx = slave_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/wb_intercon_n.sv
// Registered Wishbone classic interconnect: one master, NUM_SLAVES slaves,
// with bus error for unmapped addresses, ack watchdog and error telemetry.
module wb_intercon_n
  import wb_intercon_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE [NUM_SLAVES] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000},
  parameter logic [ADDR_WIDTH-1:0] SLAVE_MASK [NUM_SLAVES] = '{16'hC000, 16'hC000, 16'hC000, 16'hC000},
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8
)(
  input  logic                             clk,
  input  logic                             reset_in_n,
  input  logic                             m_cyc,
  input  logic                             m_stb,
  input  logic                             m_we,
  input  logic [ADDR_WIDTH-1:0]            m_adr,
  input  logic [DATA_WIDTH-1:0]            m_dat_i,
  input  logic [SEL_WIDTH-1:0]             m_sel,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic                             m_ack,
  output logic                             m_err,
  output logic [NUM_SLAVES-1:0]            s_cyc,
  output logic [NUM_SLAVES-1:0]            s_stb,
  output logic                             s_we,
  output logic [ADDR_WIDTH-1:0]            s_adr,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  output logic [SEL_WIDTH-1:0]             s_sel,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]            s_ack,
  input  logic [NUM_SLAVES-1:0]            s_err,
  output logic [7:0]                       err_count,
  output logic [3:0]                       last_err_slave
);

  intercon_state_t         state_q, state_d;
  logic                    dec_hit;
  slave_idx_t              dec_idx, idx_q, next_idx;
  logic [15:0]             wait_cnt;
  logic                    start, resp_ok, resp_err;
  logic                    sel_ack, sel_err;
  logic [DATA_WIDTH-1:0]   sel_dat;
  logic [NUM_SLAVES-1:0]   strobe_d;

  wb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .m_adr (m_adr),
    .hit   (dec_hit),
    .idx   (dec_idx)
  );

  // Only the latched slave's handshake is visible; others are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (slave_idx_t'(i) == idx_q) begin
        sel_ack = s_ack[i];
        sel_err = s_err[i];
        sel_dat = s_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    resp_ok  = 1'b0;
    resp_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_cyc && m_stb) begin
          start = 1'b1;
          if (dec_hit) begin
            state_d = ACTIVE;
          end else begin
            state_d  = RESP;
            resp_err = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!m_cyc) begin
          state_d = IDLE;
        end else if (sel_err) begin
          state_d  = RESP;
          resp_err = 1'b1;
        end else if (sel_ack) begin
          state_d = RESP;
          resp_ok = 1'b1;
        end else if (wait_cnt == 16'(TIMEOUT)) begin
          state_d  = RESP;
          resp_err = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they drop on the same edge the access ends.
  always_comb begin
    next_idx = start ? dec_idx : idx_q;
    strobe_d = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      strobe_d[i] = (state_d == ACTIVE) && (slave_idx_t'(i) == next_idx);
    end
  end

  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      s_cyc          <= '0;
      s_we           <= 1'b0;
      s_adr          <= '0;
      s_dat_o        <= '0;
      s_sel          <= '0;
      m_ack          <= 1'b0;
      m_err          <= 1'b0;
      m_dat_o        <= '0;
      err_count      <= '0;
      last_err_slave <= '0;
      idx_q          <= '0;
      wait_cnt       <= '0;
    end else begin
      s_cyc <= strobe_d;
      m_ack <= resp_ok;
      m_err <= resp_err;
      if (start) begin
        idx_q    <= dec_idx;
        s_we     <= m_we;
        s_adr    <= m_adr;
        s_dat_o  <= m_dat_i;
        s_sel    <= m_sel;
        wait_cnt <= '0;
      end else if (state_q == ACTIVE) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (resp_ok) m_dat_o <= sel_dat;
      if (resp_err) begin
        last_err_slave <= start ? UNMAPPED_IDX : idx_q;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

  assign s_stb = s_cyc;

endmodule

// File: tb/tb_wb_intercon_n.sv
// Scoreboard bench for wb_intercon_n: random accesses against a range-based
// reference model, with scripted slave responders and a decoupled monitor.
module tb_wb_intercon_n;

  localparam int unsigned TO = 8;
  localparam logic [15:0] BASE [4] = '{16'h0000, 16'h0000, 16'h8000, 16'hC000};
  localparam logic [15:0] MASK [4] = '{16'hC000, 16'h8000, 16'hC000, 16'hF000};
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_NEVER = 3;

  logic        clk = 1'b0;
  logic        reset_in_n;
  logic        m_cyc, m_stb, m_we;
  logic [15:0] m_adr, m_dat_i, m_dat_o;
  logic [1:0]  m_sel;
  logic        m_ack, m_err;
  logic [3:0]  s_cyc, s_stb;
  logic        s_we;
  logic [15:0] s_adr, s_dat_o;
  logic [1:0]  s_sel;
  logic [63:0] s_dat_i;
  logic [3:0]  s_ack, s_err;
  logic [7:0]  err_count;
  logic [3:0]  last_err_slave;

  wb_intercon_n #(
    .NUM_SLAVES (4),
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .SLAVE_BASE (BASE),
    .SLAVE_MASK (MASK),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .reset_in_n     (reset_in_n),
    .m_cyc          (m_cyc),
    .m_stb          (m_stb),
    .m_we           (m_we),
    .m_adr          (m_adr),
    .m_dat_i        (m_dat_i),
    .m_sel          (m_sel),
    .m_dat_o        (m_dat_o),
    .m_ack          (m_ack),
    .m_err          (m_err),
    .s_cyc          (s_cyc),
    .s_stb          (s_stb),
    .s_we           (s_we),
    .s_adr          (s_adr),
    .s_dat_o        (s_dat_o),
    .s_sel          (s_sel),
    .s_dat_i        (s_dat_i),
    .s_ack          (s_ack),
    .s_err          (s_err),
    .err_count      (err_count),
    .last_err_slave (last_err_slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    int unsigned lat;
    logic [15:0] data;
    bit          chk_data;
    logic [7:0]  errs;
    logic [3:0]  last;
    int unsigned issue;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          model_errs = 0;
  logic [3:0]  model_last = 4'h0;

  // Current slave plan and the bus fields expected while a slave is strobed
  int          plan_slave = -1, plan_kind = K_ACK, plan_lat = 1, plan_id = 0;
  logic [15:0] plan_data = '0;
  logic [3:0]  cur_onehot = '0;
  logic [34:0] cur_bus = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int ref_decode(input logic [15:0] a);
    if (a < 16'h4000) return 0;
    if (a < 16'h8000) return 1;
    if (a < 16'hC000) return 2;
    if (a < 16'hD000) return 3;
    return -1;
  endfunction

  // Slave responders: planned reply on the target, random noise on the rest
  int seen_id = 0, strobe_cnt = 0;
  always @(negedge clk) begin
    logic [63:0] d;
    logic [3:0]  a, e;
    d = {$urandom, $urandom};
    a = 4'($urandom);
    e = 4'($urandom);
    if (seen_id != plan_id) begin
      seen_id    = plan_id;
      strobe_cnt = 0;
    end
    if (plan_slave >= 0) begin
      a[plan_slave] = 1'b0;
      e[plan_slave] = 1'b0;
      if (s_stb[plan_slave]) begin
        strobe_cnt++;
        if (strobe_cnt == plan_lat && plan_kind != K_NEVER) begin
          a[plan_slave] = (plan_kind == K_ACK) || (plan_kind == K_BOTH);
          e[plan_slave] = (plan_kind == K_ERR) || (plan_kind == K_BOTH);
          d[plan_slave*16 +: 16] = plan_data;
        end
      end
    end
    s_dat_i = d;
    s_ack   = a;
    s_err   = e;
  end

  // Monitor: bus shape while strobed, and scoreboard pop on every response
  always @(negedge clk) begin
    exp_t x;
    if (s_stb != 4'h0) begin
      check("s_stb_onehot", s_stb, cur_onehot);
      check("s_cyc", s_cyc, cur_onehot);
      check("s_bus", {s_we, s_adr, s_dat_o, s_sel}, cur_bus);
    end
    if (m_ack || m_err) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%b%b expected=none", m_ack, m_err);
      end else begin
        x = expq.pop_front();
        check("resp_kind", {m_ack, m_err}, x.is_err ? 2'b01 : 2'b10);
        check("latency", cyc - x.issue, x.lat);
        check("s_stb_dropped", s_stb, 4'h0);
        if (x.chk_data) check("rdata", m_dat_o, x.data);
        check("err_count", err_count, x.errs);
        check("last_err_slave", last_err_slave, x.last);
      end
    end
  end

  task automatic set_plan(input logic we, input logic [15:0] adr, input logic [15:0] wdat,
                          input logic [1:0] sel, input int kind, input int lat, input logic [15:0] rdat);
    int tgt;
    tgt        = ref_decode(adr);
    plan_slave = tgt;
    plan_kind  = kind;
    plan_lat   = lat;
    plan_data  = rdat;
    plan_id++;
    cur_onehot = (tgt >= 0) ? 4'(1 << tgt) : 4'h0;
    cur_bus    = {we, adr, wdat, sel};
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat_i = wdat; m_sel = sel;
  endtask

  // Called at posedge+1; returns at posedge+1 with the bus released
  task automatic do_access(input logic we, input logic [15:0] adr, input logic [15:0] wdat,
                           input logic [1:0] sel, input int kind, input int lat, input logic [15:0] rdat);
    exp_t x;
    int   tgt;
    bit   got;
    tgt        = ref_decode(adr);
    x.issue    = cyc;
    x.data     = rdat;
    x.chk_data = 1'b0;
    if (tgt < 0) begin
      x.is_err = 1'b1; x.lat = 1; model_last = 4'hF;
    end else if (kind == K_ACK) begin
      x.is_err = 1'b0; x.lat = lat + 1; x.chk_data = !we;
    end else if (kind == K_NEVER) begin
      x.is_err = 1'b1; x.lat = TO + 2; model_last = 4'(tgt);
    end else begin
      x.is_err = 1'b1; x.lat = lat + 1; model_last = 4'(tgt);
    end
    if (x.is_err && model_errs < 255) model_errs++;
    x.errs = 8'(model_errs);
    x.last = model_last;
    expq.push_back(x);
    set_plan(we, adr, wdat, sel, kind, lat, rdat);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = m_ack || m_err;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL resp_wait actual=none expected=response adr=%h", adr);
      expq.delete();
    end
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0;
  endtask

  task automatic do_abort(input logic [15:0] adr);
    set_plan(1'b0, adr, 16'h0, 2'b11, K_NEVER, 1, 16'h0);
    repeat (2) begin @(posedge clk); #1; end
    m_cyc = 1'b0; m_stb = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_stb", s_stb, 4'h0);
    check("abort_err_count", err_count, 8'(model_errs));
  endtask

  task automatic do_reset_mid(input logic [15:0] adr);
    set_plan(1'b1, adr, 16'hCAFE, 2'b10, K_NEVER, 1, 16'h0);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_reset_stb", s_stb, cur_onehot);
    #2 reset_in_n = 1'b0;
    #1;
    check("rst_mid_strobes", {s_cyc, s_stb}, 8'h00);
    check("rst_mid_bus", {s_we, s_adr, s_dat_o, s_sel, m_ack, m_err}, 37'h0);
    check("rst_mid_regs", {m_dat_o, err_count, last_err_slave}, 28'h0);
    m_cyc = 1'b0; m_stb = 1'b0;
    model_errs = 0;
    model_last = 4'h0;
    @(posedge clk); #1;
    reset_in_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int r, kind;
    reset_in_n = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_adr = '0; m_dat_i = '0; m_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {s_cyc, s_stb}, 8'h00);
    check("rst_bus", {s_we, s_adr, s_dat_o, s_sel, m_ack, m_err}, 37'h0);
    check("rst_regs", {m_dat_o, err_count, last_err_slave}, 28'h0);
    reset_in_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    do_access(1'b0, 16'h4002, 16'h0000, 2'b11, K_ACK, 1, 16'hBEEF);
    do_access(1'b1, 16'hC010, 16'h1234, 2'b11, K_ACK, 6, 16'h5555);
    do_access(1'b0, 16'hE000, 16'h0000, 2'b11, K_ACK, 1, 16'h0000);
    do_access(1'b0, 16'h8000, 16'h0000, 2'b01, K_NEVER, 1, 16'h0000);
    do_access(1'b0, 16'h1000, 16'h0000, 2'b11, K_ACK, 2, 16'hA5A5);
    do_access(1'b0, 16'h2000, 16'h0000, 2'b11, K_BOTH, 1, 16'h0000);
    do_access(1'b0, 16'h0010, 16'h0000, 2'b11, K_ACK, TO, 16'h0F0F);
    do_abort(16'h4100);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      kind = (r < 6) ? K_ACK : (r < 8) ? K_ERR : (r < 9) ? K_BOTH : K_NEVER;
      do_access(1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
                kind, $urandom_range(1, TO), 16'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    do_reset_mid(16'h8004);

    for (int n = 0; n < 300; n++) begin
      do_access(1'b0, 16'hD000 + 16'($urandom_range(0, 16'h2FFF)), 16'h0, 2'b11,
                K_ACK, 1, 16'h0);
    end
    repeat (4) begin @(posedge clk); #1; end
    check("err_count_saturated", err_count, 8'd255);
    check("queue_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
